// File: rtl/vga_timing_gen_if.sv
// Bundles the renderer-facing request/return signals and the VGA pin outputs
// of the raster timing generator.
interface vga_timing_gen_if;
    logic [1:0]  mode;
    logic [11:0] pix_in;
    logic [10:0] curr_x;
    logic [9:0]  curr_y;
    logic        req_valid;
    logic        line_start;
    logic        frame_start;
    logic [3:0]  pix_r;
    logic [3:0]  pix_g;
    logic [3:0]  pix_b;
    logic        hsync;
    logic        vsync;
    logic        de;

    modport master (
        input  mode,
        input  pix_in,
        output curr_x,
        output curr_y,
        output req_valid,
        output line_start,
        output frame_start,
        output pix_r,
        output pix_g,
        output pix_b,
        output hsync,
        output vsync,
        output de
    );

    modport slave (
        output mode,
        output pix_in,
        input  curr_x,
        input  curr_y,
        input  req_valid,
        input  line_start,
        input  frame_start,
        input  pix_r,
        input  pix_g,
        input  pix_b,
        input  hsync,
        input  vsync,
        input  de
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters drive a combinational coordinate request,
// sync/active/pattern ride a PIX_LATENCY-deep delay line to meet the renderer colour.
module vga_timing_gen #(
    parameter int          H_ACTIVE    = 1280,
    parameter int          H_FP        = 64,
    parameter int          H_SYNC      = 136,
    parameter int          H_BP        = 200,
    parameter int          V_ACTIVE    = 800,
    parameter int          V_FP        = 1,
    parameter int          V_SYNC      = 3,
    parameter int          V_BP        = 24,
    parameter bit          H_POL       = 1'b0,
    parameter bit          V_POL       = 1'b1,
    parameter int          PIX_LATENCY = 2,
    parameter logic [11:0] BG_COLOR    = 12'h00F,
    parameter int          GRID_LOG2   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    vga_timing_gen_if.master  bus
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);

    localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_SYNC_E = HC_W'(H_SYNC);
    localparam logic [HC_W-1:0] H_ACT_S  = HC_W'(H_SYNC + H_BP);
    localparam logic [HC_W-1:0] H_ACT_L  = HC_W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_SYNC_E = VC_W'(V_SYNC);
    localparam logic [VC_W-1:0] V_ACT_S  = VC_W'(V_SYNC + V_BP);
    localparam logic [VC_W-1:0] V_ACT_L  = VC_W'(V_SYNC + V_BP + V_ACTIVE - 1);

    // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [11:0] bar_color(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = 12'hFFF;
            3'd1:    c = 12'hFF0;
            3'd2:    c = 12'h0FF;
            3'd3:    c = 12'h0F0;
            3'd4:    c = 12'hF0F;
            3'd5:    c = 12'hF00;
            3'd6:    c = 12'h00F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] bar_index(input logic [10:0] x);
        int xi;
        xi = (int'(x) * 8) / H_ACTIVE;
        return 3'(xi);
    endfunction

    function automatic logic [11:0] grid_color(input logic [10:0] x, input logic [9:0] y);
        logic on_line;
        on_line = (x[GRID_LOG2-1:0] == '0) || (y[GRID_LOG2-1:0] == '0);
        return on_line ? 12'hFFF : 12'h000;
    endfunction

    logic [HC_W-1:0] hcount_p0;
    logic [VC_W-1:0] vcount_p0;
    logic [1:0]      mode_q;

    logic            h_act_p0;
    logic            v_act_p0;
    logic [HC_W-1:0] x_off_p0;
    logic [VC_W-1:0] y_off_p0;
    logic [10:0]     x_p0;
    logic [9:0]      y_p0;
    logic            act_p0;
    logic            hs_p0;
    logic            vs_p0;
    logic            ext_p0;
    logic [11:0]     pat_p0;
    logic            frame_start_p0;

    // ---- counter stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_p0 <= '0;
            vcount_p0 <= '0;
            mode_q    <= 2'd0;
        end else if (ce) begin
            if (hcount_p0 == H_LAST) begin
                hcount_p0 <= '0;
                vcount_p0 <= (vcount_p0 == V_LAST) ? '0 : vcount_p0 + 1'b1;
            end else begin
                hcount_p0 <= hcount_p0 + 1'b1;
            end
            // Pattern selection only changes at the top of a frame.
            if (frame_start_p0)
                mode_q <= bus.mode;
        end
    end

    // ---- request stage (combinational from counters) ----
    always_comb begin
        h_act_p0       = (hcount_p0 >= H_ACT_S) && (hcount_p0 <= H_ACT_L);
        v_act_p0       = (vcount_p0 >= V_ACT_S) && (vcount_p0 <= V_ACT_L);
        x_off_p0       = hcount_p0 - H_ACT_S;
        y_off_p0       = vcount_p0 - V_ACT_S;
        x_p0           = h_act_p0 ? 11'(x_off_p0) : '1;
        y_p0           = v_act_p0 ? 10'(y_off_p0) : '1;
        act_p0         = h_act_p0 && v_act_p0;
        hs_p0          = (hcount_p0 < H_SYNC_E) ? H_POL : ~H_POL;
        vs_p0          = (vcount_p0 < V_SYNC_E) ? V_POL : ~V_POL;
        frame_start_p0 = (hcount_p0 == '0) && (vcount_p0 == '0);
        ext_p0         = (mode_q == 2'd0);
        case (mode_q)
            2'd1:    pat_p0 = BG_COLOR;
            2'd2:    pat_p0 = bar_color(bar_index(x_p0));
            2'd3:    pat_p0 = grid_color(x_p0, y_p0);
            default: pat_p0 = 12'h000;
        endcase
    end

    assign bus.curr_x      = x_p0;
    assign bus.curr_y      = y_p0;
    assign bus.req_valid   = act_p0;
    assign bus.line_start  = (hcount_p0 == '0);
    assign bus.frame_start = frame_start_p0;

    logic        hs_p1;
    logic        vs_p1;
    logic        act_p1;
    logic        ext_p1;
    logic [11:0] pat_p1;

    // ---- delay line: matches the renderer's colour return latency ----
    generate
        if (PIX_LATENCY == 0) begin : g_nodly
            assign hs_p1  = hs_p0;
            assign vs_p1  = vs_p0;
            assign act_p1 = act_p0;
            assign ext_p1 = ext_p0;
            assign pat_p1 = pat_p0;
        end else begin : g_dly
            logic [PIX_LATENCY-1:0] hs_dl;
            logic [PIX_LATENCY-1:0] vs_dl;
            logic [PIX_LATENCY-1:0] act_dl;
            logic [PIX_LATENCY-1:0] ext_dl;
            logic [11:0]            pat_dl [PIX_LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hs_dl  <= {PIX_LATENCY{~H_POL}};
                    vs_dl  <= {PIX_LATENCY{~V_POL}};
                    act_dl <= '0;
                    ext_dl <= '0;
                end else if (ce) begin
                    hs_dl[0]  <= hs_p0;
                    vs_dl[0]  <= vs_p0;
                    act_dl[0] <= act_p0;
                    ext_dl[0] <= ext_p0;
                    for (int i = 1; i < PIX_LATENCY; i++) begin
                        hs_dl[i]  <= hs_dl[i-1];
                        vs_dl[i]  <= vs_dl[i-1];
                        act_dl[i] <= act_dl[i-1];
                        ext_dl[i] <= ext_dl[i-1];
                    end
                end
            end

            // Pattern data needs no reset: it is masked by the delayed active flag.
            always_ff @(posedge clk) begin
                if (ce) begin
                    pat_dl[0] <= pat_p0;
                    for (int i = 1; i < PIX_LATENCY; i++)
                        pat_dl[i] <= pat_dl[i-1];
                end
            end

            assign hs_p1  = hs_dl[PIX_LATENCY-1];
            assign vs_p1  = vs_dl[PIX_LATENCY-1];
            assign act_p1 = act_dl[PIX_LATENCY-1];
            assign ext_p1 = ext_dl[PIX_LATENCY-1];
            assign pat_p1 = pat_dl[PIX_LATENCY-1];
        end
    endgenerate

    logic        hs_p2;
    logic        vs_p2;
    logic        de_p2;
    logic [11:0] rgb_p2;

    // ---- output stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_p2  <= ~H_POL;
            vs_p2  <= ~V_POL;
            de_p2  <= 1'b0;
            rgb_p2 <= 12'h000;
        end else if (ce) begin
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            de_p2  <= act_p1;
            rgb_p2 <= act_p1 ? (ext_p1 ? bus.pix_in : pat_p1) : 12'h000;
        end
    end

    assign bus.hsync = hs_p2;
    assign bus.vsync = vs_p2;
    assign bus.de    = de_p2;
    assign bus.pix_r = rgb_p2[11:8];
    assign bus.pix_g = rgb_p2[7:4];
    assign bus.pix_b = rgb_p2[3:0];

endmodule
